// File: rtl/disp_pkg.sv
// Shared types and constants for the multiplexed 7-segment scan controller.
// Segment patterns are active-low, anodes are active-low.
package disp_pkg;

    localparam logic [6:0] SEG_OFF = 7'b1111111;
    localparam int         AN_MAX  = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GUARD,
        ST_SHOW
    } state_t;

    function automatic logic [AN_MAX-1:0] an_off();
        return '1;
    endfunction

    function automatic logic [AN_MAX-1:0] an_sel(input int i);
        return ~(AN_MAX'(1) << i);
    endfunction

endpackage

// File: rtl/disp_scan_ctrl_bcdtosseg.sv
// Hex nibble to active-low 7-segment decoder, segments a..g with a as MSB.
// sacom is the common-anode enable for boards that route it.
module BCDtoSSeg (
    input  logic [3:0] bcd,
    output logic [6:0] sseg,
    output logic       sacom
);

    assign sacom = 1'b1;

    always_comb begin
        sseg = 7'b1111111;
        unique case (bcd)
            4'h0: sseg = 7'b0000001;
            4'h1: sseg = 7'b1001111;
            4'h2: sseg = 7'b0010010;
            4'h3: sseg = 7'b0000110;
            4'h4: sseg = 7'b1001100;
            4'h5: sseg = 7'b0100100;
            4'h6: sseg = 7'b0100000;
            4'h7: sseg = 7'b0001111;
            4'h8: sseg = 7'b0000000;
            4'h9: sseg = 7'b0000100;
            4'hA: sseg = 7'b0001000;
            4'hB: sseg = 7'b1100000;
            4'hC: sseg = 7'b0110001;
            4'hD: sseg = 7'b1000010;
            4'hE: sseg = 7'b0110000;
            4'hF: sseg = 7'b0111000;
        endcase
    end

endmodule

// File: rtl/disp_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode multi-digit display.
// Values are double-buffered and committed only when digit 0 is entered.
module disp_scan_ctrl #(
    parameter int NDIGITS = 4,
    parameter int DWELL   = 50000,
    parameter int GUARD   = 500
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [4*NDIGITS-1:0] value,
    input  logic                 load,
    input  logic                 blank_lz,
    output logic [6:0]           sseg,
    output logic [NDIGITS-1:0]   an,
    output logic                 frame_done
);
    import disp_pkg::*;

    localparam int MAXC = (DWELL > GUARD) ? DWELL : GUARD;
    localparam int CW   = $clog2(MAXC + 1);
    localparam int IW   = $clog2(NDIGITS);

    localparam logic [CW-1:0] D_LAST = CW'(DWELL - 1);
    localparam logic [CW-1:0] G_LAST = CW'((GUARD > 0) ? GUARD - 1 : 0);
    localparam logic [IW-1:0] I_LAST = IW'(NDIGITS - 1);

    state_t               state, state_nxt;
    logic [IW-1:0]        idx, idx_nxt;
    logic [CW-1:0]        cnt, cnt_nxt;
    logic [4*NDIGITS-1:0] pend, pend_nxt;
    logic [4*NDIGITS-1:0] disp, disp_nxt;
    logic                 pend_v, pend_v_nxt;
    logic                 commit, fd_nxt, lz;
    logic [3:0]           nib;
    logic [6:0]           seg_dec, sseg_nxt;
    logic [NDIGITS-1:0]   an_nxt;

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        cnt_nxt   = cnt;
        commit    = 1'b0;
        fd_nxt    = 1'b0;
        if (!enable) begin
            state_nxt = ST_IDLE;
            idx_nxt   = '0;
            cnt_nxt   = '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    idx_nxt   = '0;
                    cnt_nxt   = '0;
                    commit    = 1'b1;
                    state_nxt = (GUARD > 0) ? ST_GUARD : ST_SHOW;
                end
                ST_GUARD: begin
                    if (cnt == G_LAST) begin
                        cnt_nxt   = '0;
                        state_nxt = ST_SHOW;
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
                ST_SHOW: begin
                    if (cnt == D_LAST) begin
                        cnt_nxt   = '0;
                        state_nxt = (GUARD > 0) ? ST_GUARD : ST_SHOW;
                        if (idx == I_LAST) begin
                            idx_nxt = '0;
                            commit  = 1'b1;
                            fd_nxt  = 1'b1;
                        end else begin
                            idx_nxt = idx + IW'(1);
                        end
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // A load coinciding with the commit edge bypasses the pending buffer.
    always_comb begin
        pend_nxt   = pend;
        pend_v_nxt = pend_v;
        disp_nxt   = disp;
        if (commit) begin
            if (load) begin
                disp_nxt   = value;
                pend_nxt   = value;
                pend_v_nxt = 1'b0;
            end else if (pend_v) begin
                disp_nxt   = pend;
                pend_v_nxt = 1'b0;
            end
        end else if (load) begin
            pend_nxt   = value;
            pend_v_nxt = 1'b1;
        end
    end

    always_comb begin
        lz = blank_lz && (idx_nxt != '0);
        for (int i = 0; i < NDIGITS; i++) begin
            if (i >= int'(idx_nxt) && disp_nxt[4*i +: 4] != 4'h0)
                lz = 1'b0;
        end
    end

    assign nib = disp_nxt[{idx_nxt, 2'b00} +: 4];

    BCDtoSSeg u_dec (
        .bcd   (nib),
        .sseg  (seg_dec),
        .sacom ()
    );

    always_comb begin
        an_nxt   = NDIGITS'(an_off());
        sseg_nxt = SEG_OFF;
        if (state_nxt == ST_SHOW && !lz) begin
            an_nxt   = NDIGITS'(an_sel(int'(idx_nxt)));
            sseg_nxt = seg_dec;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            idx        <= '0;
            cnt        <= '0;
            pend       <= '0;
            pend_v     <= 1'b0;
            disp       <= '0;
            an         <= '1;
            sseg       <= SEG_OFF;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            idx        <= idx_nxt;
            cnt        <= cnt_nxt;
            pend       <= pend_nxt;
            pend_v     <= pend_v_nxt;
            disp       <= disp_nxt;
            an         <= an_nxt;
            sseg       <= sseg_nxt;
            frame_done <= fd_nxt;
        end
    end

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Randomized and directed bench for disp_scan_ctrl with a per-cycle scoreboard.
// The reference model derives outputs from the position inside the frame.
module tb_disp_scan_ctrl;

    localparam int ND    = 4;
    localparam int DW    = 4;
    localparam int GD    = 1;
    localparam int SLOT  = DW + GD;
    localparam int FRAME = ND * SLOT;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] sseg;
        logic       fd;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [15:0] value;
    logic        load;
    logic        blank_lz;
    logic [6:0]  sseg;
    logic [3:0]  an;
    logic        frame_done;

    int checks   = 0;
    int failures = 0;

    exp_t exp_q[$];

    logic [6:0] seg_tbl [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    disp_scan_ctrl #(
        .NDIGITS (ND),
        .DWELL   (DW),
        .GUARD   (GD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .value      (value),
        .load       (load),
        .blank_lz   (blank_lz),
        .sseg       (sseg),
        .an         (an),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Reference model: active flag, frame position and buffered values.
    bit          m_act = 1'b0;
    int          m_t   = 0;
    logic [15:0] m_disp = '0;
    logic [15:0] m_pend = '0;
    bit          m_pv  = 1'b0;

    initial begin
        exp_t e;
        bit   cm;
        bit   fd;
        bit   blank;
        int   slot;
        int   off;
        forever begin
            @(posedge clk);
            if (rst) begin
                m_act  = 1'b0;
                m_t    = 0;
                m_disp = '0;
                m_pend = '0;
                m_pv   = 1'b0;
                e      = '{an: 4'hF, sseg: 7'h7F, fd: 1'b0};
            end else begin
                cm = 1'b0;
                fd = 1'b0;
                if (!enable) begin
                    m_act = 1'b0;
                end else if (!m_act) begin
                    m_act = 1'b1;
                    m_t   = 0;
                    cm    = 1'b1;
                end else begin
                    m_t = m_t + 1;
                    if (m_t == FRAME) begin
                        m_t = 0;
                        cm  = 1'b1;
                        fd  = 1'b1;
                    end
                end
                if (cm) begin
                    if (load) begin
                        m_disp = value;
                        m_pv   = 1'b0;
                    end else if (m_pv) begin
                        m_disp = m_pend;
                        m_pv   = 1'b0;
                    end
                end else if (load) begin
                    m_pend = value;
                    m_pv   = 1'b1;
                end
                e    = '{an: 4'hF, sseg: 7'h7F, fd: fd};
                slot = m_t / SLOT;
                off  = m_t % SLOT;
                if (m_act && off >= GD) begin
                    blank = blank_lz && slot != 0 &&
                            (m_disp >> (4 * slot)) == 16'h0;
                    if (!blank) begin
                        e.an   = ~(4'b0001 << slot);
                        e.sseg = seg_tbl[m_disp[4*slot +: 4]];
                    end
                end
            end
            exp_q.push_back(e);
        end
    end

    initial begin
        exp_t e;
        @(posedge clk);
        forever begin
            @(negedge clk);
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL scoreboard_empty: no expected entry at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                if ({an, sseg, frame_done} !== e) begin
                    failures++;
                    $display("FAIL scan_out @%0t: an=%b sseg=%b fd=%b, want an=%b sseg=%b fd=%b",
                             $time, an, sseg, frame_done, e.an, e.sseg, e.fd);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_an(input logic [3:0] tgt, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (an !== tgt && n < 200);
        if (an !== tgt)
            chk("wait_an_timeout", 32'(an), 32'(tgt));
    endtask

    task automatic wait_fd(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (frame_done !== 1'b1 && n < 200);
        if (frame_done !== 1'b1)
            chk("wait_fd_timeout", 32'(frame_done), 32'd1);
    endtask

    function automatic logic [15:0] rand_val();
        logic [15:0] v;
        v = '0;
        for (int i = 0; i < 4; i++)
            if ($urandom_range(0, 1) == 1)
                v[4*i +: 4] = 4'($urandom_range(0, 15));
        return v;
    endfunction

    initial begin
        int          n;
        int          k;
        int          r;
        logic [3:0]  lit_an;

        rst      = 1'b1;
        enable   = 1'b1;
        load     = 1'b1;
        value    = 16'h1234;
        blank_lz = 1'b0;
        repeat (3) tick();
        chk("reset_an", 32'(an), 32'hF);
        chk("reset_sseg", 32'(sseg), 32'h7F);
        chk("reset_fd", 32'(frame_done), 32'd0);

        // Basic scan; the load is taken on the edge leaving idle.
        rst = 1'b0;
        tick();
        load = 1'b0;
        wait_an(4'b1110, n);
        chk("first_show_latency", 32'(n + 1), 32'd2);
        chk("scan_d0", 32'(sseg), 32'(7'b1001100));
        wait_an(4'b1101, n);
        chk("scan_d1", 32'(sseg), 32'(7'b0000110));
        wait_an(4'b1011, n);
        chk("scan_d2", 32'(sseg), 32'(7'b0010010));
        wait_an(4'b0111, n);
        chk("scan_d3", 32'(sseg), 32'(7'b1001111));
        wait_fd(n);
        wait_fd(n);
        chk("frame_period", 32'(n), 32'(FRAME));

        // Leading-zero suppression.
        enable = 1'b0;
        tick();
        blank_lz = 1'b1;
        load     = 1'b1;
        value    = 16'h0040;
        tick();
        load   = 1'b0;
        enable = 1'b1;
        wait_an(4'b1110, n);
        chk("lz_d0", 32'(sseg), 32'(7'b0000001));
        wait_an(4'b1101, n);
        chk("lz_d1", 32'(sseg), 32'(7'b1001100));
        repeat (DW - 1) tick();
        k = 0;
        do begin
            tick();
            k++;
        end while (an === 4'hF && k < 40);
        chk("lz_dark_cycles", 32'(k - 1), 32'd11);
        chk("lz_next_d0", 32'(an), 32'(4'b1110));
        load  = 1'b1;
        value = 16'h0000;
        tick();
        load = 1'b0;
        wait_fd(n);
        wait_fd(n);
        k      = 0;
        lit_an = 4'hF;
        repeat (FRAME) begin
            tick();
            if (an !== 4'hF) begin
                k++;
                lit_an = an;
            end
        end
        chk("zero_lit_cycles", 32'(k), 32'(DW));
        chk("zero_lit_an", 32'(lit_an), 32'(4'b1110));

        // Tear-free update mid-frame.
        enable = 1'b0;
        tick();
        blank_lz = 1'b0;
        load     = 1'b1;
        value    = 16'h1234;
        tick();
        load   = 1'b0;
        enable = 1'b1;
        wait_an(4'b1101, n);
        load  = 1'b1;
        value = 16'hABCD;
        tick();
        load = 1'b0;
        wait_an(4'b1011, n);
        chk("tear_d2_old", 32'(sseg), 32'(7'b0010010));
        wait_an(4'b0111, n);
        chk("tear_d3_old", 32'(sseg), 32'(7'b1001111));
        wait_an(4'b1110, n);
        chk("tear_d0_new", 32'(sseg), 32'(7'b1000010));

        // Load landing exactly on the wrap edge.
        wait_an(4'b1011, n);
        wait_an(4'b0111, n);
        repeat (DW - 1) tick();
        load  = 1'b1;
        value = 16'h5555;
        tick();
        load = 1'b0;
        wait_an(4'b1110, n);
        chk("commit_edge_d0", 32'(sseg), 32'(7'b0100100));
        chk("commit_edge_pend_v", 32'(dut.pend_v), 32'd0);

        // Enable drop mid digit 2, then restart.
        wait_an(4'b1011, n);
        enable = 1'b0;
        tick();
        chk("drop_an", 32'(an), 32'hF);
        chk("drop_sseg", 32'(sseg), 32'h7F);
        chk("drop_fd", 32'(frame_done), 32'd0);
        repeat (2) tick();
        enable = 1'b1;
        wait_an(4'b1110, n);
        chk("restart_latency", 32'(n), 32'(GD + 1));

        // Async reset mid-guard and mid-show.
        repeat (DW) tick();
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("rst_guard_an", 32'(an), 32'hF);
        chk("rst_guard_fd", 32'(frame_done), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        wait_an(4'b1110, n);
        chk("rst_restart_latency", 32'(n), 32'(GD + 1));
        wait_an(4'b1101, n);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("rst_show_an", 32'(an), 32'hF);
        chk("rst_show_sseg", 32'(sseg), 32'h7F);
        @(posedge clk);
        #1 rst = 1'b0;
        wait_an(4'b1110, n);
        chk("rst_disp_cleared", 32'(sseg), 32'(7'b0000001));

        // Randomized traffic.
        for (int c = 0; c < 1500; c++) begin
            r     = $urandom_range(0, 99);
            load  = (r < 12);
            value = rand_val();
            if (enable && r == 99)
                enable = 1'b0;
            else if (!enable && r >= 90)
                enable = 1'b1;
            if (!enable && r < 30)
                blank_lz = 1'($urandom_range(0, 1));
            tick();
        end
        load   = 1'b0;
        enable = 1'b1;
        repeat (5) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/disp_scan_ctrl.md
# disp_scan_ctrl

Time-multiplexed scan controller for a common-anode multi-digit 7-segment display. It shares one `BCDtoSSeg` decoder across `NDIGITS` digits by cycling the digit anodes, and it holds each digit for a programmable dwell with an all-off guard gap in between. New display values are double-buffered and committed only at frame boundaries, so a digit never shows a mix of old and new data. Optional leading-zero suppression is provided. It sits between the counter/ALU datapath and the board's segment/anode pins.

## Interface
- `NDIGITS`, 4: number of digits scanned (≥2).
- `DWELL`, 50000: clock cycles each digit is lit (≥1).
- `GUARD`, 500: all-anodes-off clock cycles between digits (≥0; 0 means no guard state).
- `clk` in 1: single system clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `enable` in 1: scanning enabled; low blanks the display.
- `value` in 4*NDIGITS: hex/BCD nibbles; nibble i maps to digit i, and digit 0 is least significant.
- `load` in 1: single-cycle strobe that captures `value` into the pending register.
- `blank_lz` in 1: enables leading-zero suppression.
- `sseg` out 7: segments a..g, a is the MSB, active-low (decoder encoding).
- `an` out NDIGITS: digit anodes, active-low, at most one low at a time.
- `frame_done` out 1: one-cycle pulse when the last digit's dwell ends.

## Operation
- Registers:
  - `pend` (4*NDIGITS) plus `pend_v` flag.
  - `disp` (4*NDIGITS), the committed value.
  - digit index `idx`.
  - cycle counter `cnt`.
  - FSM state.
- States and transitions:
  - IDLE → (enable) → GUARD if GUARD>0, else SHOW; idx=0.
  - GUARD → after GUARD cycles → SHOW.
  - SHOW → after DWELL cycles → idx=(idx+1) mod NDIGITS, then GUARD (or SHOW if GUARD=0).
  - Any state → IDLE on the edge after `enable` is sampled low. idx=0 and cnt=0 in IDLE.
- Load: `load`=1 sets `pend`=`value` and `pend_v`=1. A second load before commit overwrites `pend`.
- Commit: on every transition that enters digit 0 (wrap from digit NDIGITS-1, or leaving IDLE):
  - If `pend_v`, then `disp`=`pend` and `pend_v`=0.
  - If `load` is high on the commit edge, `value` is committed directly and `pend_v` stays 0.
- Leading-zero suppression (`blank_lz`=1):
  - Digit i is blanked if nibbles NDIGITS-1..i of `disp` are all zero and i≠0.
  - Digit 0 is never blanked.
  - A blanked digit keeps its anode high and `sseg` at 7'b1111111 during its SHOW slot. Slot timing is unchanged.
- Nibbles A–F display using the decoder's glyphs. No BCD range checking is done.

## Timing
- Reset values: `an`=all 1s, `sseg`=7'b1111111, `frame_done`=0, state IDLE, idx=0, cnt=0, `disp`=0, `pend`=0, `pend_v`=0.
- `an` and `sseg` are registered and change on the same edge as the state:
  - On the edge entering SHOW(idx): `an`[idx]=0 and `sseg`=decode(`disp` nibble idx).
  - On the edge entering GUARD or IDLE: all off.
- A digit is lit for exactly DWELL cycles. Frame length is NDIGITS*(DWELL+GUARD) cycles.
- `frame_done` is high for the single cycle after the last SHOW cycle of digit NDIGITS-1. It is not asserted when a frame is aborted by `enable` low.
- Load-to-visible latency: from the next commit edge, at most one frame plus one cycle.
- Async `rst` mid-frame forces all reset values immediately. The first SHOW occurs GUARD+1 cycles after release with `enable`=1.

## Structure
- Shared package `disp_pkg`:
  - `SEG_OFF`=7'b1111111.
  - `AN_OFF` helper.
  - FSM state enum {IDLE, GUARD, SHOW}.
- Sub-module: one `BCDtoSSeg` instance fed by a mux of `disp` nibble idx. Its `sacom` output is left unconnected.
- Counter width is clog2(max(DWELL,GUARD)+1).

## Test plan
Bench configuration: NDIGITS=4, DWELL=4, GUARD=1.

- **Reset:** assert `rst` → `an`=4'b1111, `sseg`=7'b1111111, `frame_done`=0. Holds with `enable`=1 until release.
- **Basic scan:** load 16'h1234, `enable`=1 → each digit lit 4 cycles with 1-cycle gaps, `frame_done` every 20 cycles:
  - after first commit, `an`=4'b1110 with `sseg`=7'b1001100 ("4");
  - then 4'b1101 with 7'b0000110;
  - then 4'b1011 with 7'b0010010;
  - then 4'b0111 with 7'b1001111.
- **Leading zeros:** `blank_lz`=1 with 16'h0040 → digits 0 and 1 show 7'b0000001 and 7'b1001100; digit 2/3 slots keep `an`=4'b1111. With 16'h0000 → only digit 0 is lit, showing "0".
- **Tear-free update:** load 16'hABCD during digit 1 SHOW → digits 2 and 3 still show the old value; new digit 0 shows 7'b1000010 ("d") in the next frame.
- **Load on commit edge:** `load` with 16'h5555 on the wrap edge → digit 0 shows 7'b0100100 in the same frame and `pend_v`=0.
- **Enable drop / async reset:** `enable`=0 mid-SHOW of digit 2 → `an`=4'b1111 next cycle and no `frame_done`. Re-enable restarts at digit 0 after 1 guard cycle. `rst` pulsed mid-GUARD → immediate reset values.
